// File: rtl/sha3_pkg.sv
// Shared constants and state encoding for the SHA3-256 block padder.
// Lane width, rate size and pad bytes used by the padder and its lane helper.
package sha3_pkg;

  localparam int LANE_W = 64;
  localparam int RATE_BYTES = 136;
  localparam logic [7:0] DOMAIN_SHA3 = 8'h06;
  localparam logic [7:0] PAD_END = 8'h80;

  typedef enum logic [1:0] {
    FILL,
    FULL,
    PADBLK
  } pad_state_t;

endpackage

// File: rtl/sha3_pad_lane.sv
// Combinational lane padder: masks unused bytes of a final lane and
// inserts the domain byte and, on the last rate lane, the closing 0x80.
module sha3_pad_lane
  import sha3_pkg::*;
#(
  parameter logic [7:0] DOMAIN = DOMAIN_SHA3
) (
  input  logic [LANE_W-1:0] lane,
  input  logic [3:0]        n_bytes,
  input  logic              is_last,
  input  logic              is_final_lane,
  output logic [LANE_W-1:0] padded
);

  logic [3:0] n;

  // Clamp byte count, zero the tail, place domain and end-of-block bytes.
  always_comb begin
    n = (n_bytes > 4'd8) ? 4'd8 : n_bytes;
    padded = lane;
    if (is_last) begin
      for (int b = 0; b < 8; b++) begin
        if (4'(b) > n) begin
          padded[8*b +: 8] = 8'h00;
        end else if (4'(b) == n) begin
          padded[8*b +: 8] = DOMAIN;
        end
      end
      if (is_final_lane && (n != 4'd8)) begin
        padded[LANE_W-1 -: 8] = padded[LANE_W-1 -: 8] ^ PAD_END;
      end
    end
  end

endmodule

// File: rtl/sha3_padder.sv
// Assembles 64-bit message lanes into padded SHA3-256 rate blocks and
// hands each block downstream over a valid/ready handshake.
module sha3_padder
  import sha3_pkg::*;
#(
  parameter int         RATE_LANES = 17,
  parameter logic [7:0] DOMAIN     = DOMAIN_SHA3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [63:0]                in_data,
  input  logic                       in_last,
  input  logic [3:0]                 in_bytes,
  output logic                       blk_valid,
  input  logic                       blk_ready,
  output logic [64*RATE_LANES-1:0]   blk_data,
  output logic                       blk_last
);

  localparam int CW = $clog2(RATE_LANES);
  localparam logic [CW-1:0] LAST_IDX = CW'(RATE_LANES - 1);
  localparam logic [CW-1:0] PRE_IDX = CW'(RATE_LANES - 2);
  localparam logic [LANE_W-1:0] END_LANE =
    {PAD_END, {(LANE_W-8){1'b0}}};
  localparam logic [LANE_W-1:0] DOM_LANE =
    {{(LANE_W-8){1'b0}}, DOMAIN};

  pad_state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic [RATE_LANES-1:0][LANE_W-1:0] buffer;
  logic pad_pend;

  logic accept;
  logic lane_last;
  logic full8;
  logic spill;
  logic pend_set;
  logic blk_done;
  logic [LANE_W-1:0] cur_lane;
  logic [LANE_W-1:0] next_lane;

  assign in_ready  = (state == FILL);
  assign blk_valid = (state == FULL);
  assign blk_data  = buffer;

  assign accept    = in_valid && in_ready;
  assign lane_last = (cnt == LAST_IDX);
  assign full8     = (in_bytes >= 4'd8);
  assign spill     = in_last && full8 && !lane_last;
  assign pend_set  = in_last && full8 && lane_last;
  assign blk_done  = accept && (in_last || lane_last);

  sha3_pad_lane #(.DOMAIN(DOMAIN)) u_cur (
    .lane          (in_data),
    .n_bytes       (in_bytes),
    .is_last       (in_last),
    .is_final_lane (lane_last),
    .padded        (cur_lane)
  );

  // A full final lane pushes the domain byte into the following lane.
  sha3_pad_lane #(.DOMAIN(DOMAIN)) u_next (
    .lane          ({LANE_W{1'b0}}),
    .n_bytes       (4'd0),
    .is_last       (1'b1),
    .is_final_lane (cnt == PRE_IDX),
    .padded        (next_lane)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FILL;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: fill lanes, present block, optionally emit pad-only block.
  always_comb begin
    state_nx = state;
    unique case (state)
      FILL: begin
        if (blk_done) begin
          state_nx = FULL;
        end
      end
      FULL: begin
        if (blk_ready) begin
          state_nx = pad_pend ? PADBLK : FILL;
        end
      end
      PADBLK: state_nx = FULL;
      default: state_nx = FILL;
    endcase
  end

  // Lane buffer, lane counter, pad-pending flag and block-last flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      buffer   <= '0;
      pad_pend <= 1'b0;
      blk_last <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (accept) begin
            if (in_last && !lane_last) begin
              buffer[LAST_IDX] <= END_LANE;
            end
            buffer[cnt] <= cur_lane;
            if (spill) begin
              buffer[cnt + CW'(1)] <= next_lane;
            end
            if (blk_done) begin
              cnt      <= '0;
              blk_last <= in_last && !pend_set;
              pad_pend <= pend_set;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        FULL: begin
          if (blk_ready) begin
            buffer   <= '0;
            blk_last <= 1'b0;
          end
        end
        PADBLK: begin
          buffer           <= '0;
          buffer[0]        <= DOM_LANE;
          buffer[LAST_IDX] <= END_LANE;
          blk_last         <= 1'b1;
          pad_pend         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
